// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and parameter limits for the tx and rx paths
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // data_xor is the XOR of all data bits; odd parity makes the total count of ones odd
  function automatic logic parity_of(input logic data_xor, input int mode);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - word handshake between the upstream source and the serializer
interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_strobe.sv
// rtl/uart_baud_strobe.sv - turns each baud_clock edge into a one-clk bit strobe
module uart_baud_strobe (
  input  logic clk,
  input  logic reset,
  input  logic baud_clock,
  output logic strobe
);

  logic baud_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) baud_q <= 1'b0;
    else       baud_q <= baud_clock;
  end

  assign strobe = baud_clock ^ baud_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmitter: start, LSB-first data, optional parity, stop bits
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_clock,
  uart_tx_serializer_if.slave  up,
  output logic                 tx,
  output logic                 busy
);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $fatal(1, "uart_tx_serializer: DATA_BITS must be 5..8");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $fatal(1, "uart_tx_serializer: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $fatal(1, "uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  state_t               state, state_d;
  logic [DATA_BITS-1:0] sr, sr_d;
  logic [2:0]           cnt, cnt_d;
  logic                 par_q, par_d;
  logic                 tx_d;
  logic                 strobe;
  logic                 hs;
  logic                 last_data;
  logic                 last_stop;

  uart_baud_strobe u_strobe (
    .clk        (clk),
    .reset      (reset),
    .baud_clock (baud_clock),
    .strobe     (strobe)
  );

  assign up.tx_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign hs          = up.tx_valid && (state == IDLE);
  assign last_data   = (cnt == 3'(DATA_BITS - 1));
  assign last_stop   = (cnt == 3'(STOP_BITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // A strobe coincident with the handshake is ignored because IDLE never looks at it
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (hs) state_d = ALIGN;
      ALIGN:   if (strobe) state_d = START;
      START:   if (strobe) state_d = DATA;
      DATA:    if (strobe && last_data) state_d = (PARITY != PAR_NONE) ? PAR : STOP;
      PAR:     if (strobe) state_d = STOP;
      STOP:    if (strobe && last_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d  = tx;
    sr_d  = sr;
    cnt_d = cnt;
    par_d = par_q;
    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (hs) begin
          sr_d  = up.tx_data;
          par_d = parity_of(^up.tx_data, PARITY);
        end
      end
      ALIGN: if (strobe) tx_d = 1'b0;
      START: begin
        if (strobe) begin
          tx_d  = sr[0];
          cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (strobe) begin
          sr_d = {1'b0, sr[DATA_BITS-1:1]};
          if (last_data) begin
            tx_d  = (PARITY != PAR_NONE) ? par_q : 1'b1;
            cnt_d = 3'd0;
          end else begin
            tx_d  = sr[1];
            cnt_d = cnt + 3'd1;
          end
        end
      end
      PAR: begin
        if (strobe) begin
          tx_d  = 1'b1;
          cnt_d = 3'd0;
        end
      end
      STOP:    if (strobe && !last_stop) cnt_d = cnt + 3'd1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx    <= 1'b1;
      sr    <= '0;
      cnt   <= 3'd0;
      par_q <= 1'b0;
    end else begin
      tx    <= tx_d;
      sr    <= sr_d;
      cnt   <= cnt_d;
      par_q <= par_d;
    end
  end

endmodule
